mux8_scan_ctrl: RTL and testbench

MUX8_SCAN_CTRL -- requirements
Module: mux8_scan_ctrl

---
 rtl/mux8_scan_pkg.sv | 24 ++
 rtl/scan_dwell_timer.sv | 42 ++++
 rtl/mux8_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux8_scan_pkg                                                 |
// | Purpose  : Shared widths, constants and state encoding for the mux scan. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mux8_scan_pkg;

    localparam int c_sel_w  = 3;
    localparam int c_data_w = 8;
    localparam int c_cnt_w  = 4;

    localparam logic [c_sel_w-1:0] c_sel_first = 3'd0;
    localparam logic [c_sel_w-1:0] c_sel_last  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

endpackage : mux8_scan_pkg
`default_nettype wire

// File: rtl/scan_dwell_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : scan_dwell_timer                                              |
// | Purpose  : Loadable down-counter that stops at zero; times settle dwell. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module scan_dwell_timer
    import mux8_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [c_cnt_w-1:0] load_val,
    input  logic               tick,
    output logic               zero
);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    // Load has priority so a reload in the sampling cycle never loses a tick.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : scan_dwell_timer
`default_nettype wire

// File: rtl/mux8_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux8_scan_ctrl                                                |
// | Purpose  : Walks an external 8:1 mux through all selects, settling DWELL |
// |            cycles per select, and rebuilds the word from its output.     |
// |            Define MUX8_SCAN_CHECK_EN to add the sticky mismatch check.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mux8_scan_ctrl
    import mux8_scan_pkg::*;
#(
    parameter int unsigned DWELL = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [c_data_w-1:0] data_in,
    output logic                busy,
    output logic                mux_en,
    output logic [c_sel_w-1:0]  mux_sel,
    output logic [c_data_w-1:0] mux_in,
    input  logic                mux_out,
    output logic [c_data_w-1:0] result,
`ifdef MUX8_SCAN_CHECK_EN
    output logic                mismatch,
`endif
    output logic                done
);

    localparam logic [c_cnt_w-1:0] c_dwell_load = c_cnt_w'(DWELL - 1);

    scan_state_e         state_q;
    scan_state_e         state_d;
    logic [c_sel_w-1:0]  sel_q;
    logic [c_sel_w-1:0]  sel_d;
    logic [c_data_w-1:0] mux_in_q;
    logic [c_data_w-1:0] mux_in_d;
    logic [c_data_w-1:0] result_q;
    logic [c_data_w-1:0] result_d;
    logic                en_q;
    logic                en_d;

    logic w_load;
    logic w_tick;
    logic w_zero;

    scan_dwell_timer u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (c_dwell_load),
        .tick     (w_tick),
        .zero     (w_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        mux_in_d = mux_in_q;
        result_d = result_q;
        en_d     = en_q;
        w_load   = 1'b0;
        w_tick   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mux_in_d = data_in;
                    sel_d    = c_sel_first;
                    en_d     = 1'b1;
                    result_d = '0;
                    w_load   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_tick = 1'b1;
                if (w_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                result_d[sel_q] = mux_out;
                // Select is left at the last value after a scan; only start reloads it.
                if (sel_q == c_sel_last) begin
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    w_load  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            mux_in_q <= '0;
            result_q <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            mux_in_q <= mux_in_d;
            result_q <= result_d;
            en_q     <= en_d;
        end
    end

`ifdef MUX8_SCAN_CHECK_EN
    logic mism_q;
    logic mism_d;

    // Sticky across the whole scan so any single bad sample is reported at done.
    always_comb begin
        mism_d = mism_q;
        if ((state_q == ST_IDLE) && start) begin
            mism_d = 1'b0;
        end else if ((state_q == ST_SAMPLE) && (mux_out != mux_in_q[sel_q])) begin
            mism_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q <= 1'b0;
        end else begin
            mism_q <= mism_d;
        end
    end

    assign mismatch = mism_q;
`endif

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign mux_en  = en_q;
    assign mux_sel = sel_q;
    assign mux_in  = mux_in_q;
    assign result  = result_q;

endmodule : mux8_scan_ctrl
`default_nettype wire

// File: tb/tb_mux8_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux8_scan_ctrl                                             |
// | Purpose  : Scoreboard bench for mux8_scan_ctrl at DWELL=5 and DWELL=1.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mux8_scan_ctrl;

    localparam int unsigned DW0  = 5;
    localparam int unsigned DW1  = 1;
    localparam int unsigned LAT0 = 8 * (DW0 + 1);
    localparam int unsigned LAT1 = 8 * (DW1 + 1);

    typedef struct {
        logic [7:0]  res;
        logic        mism;
        int unsigned cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          errors = 0;
    int          checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       busy0, busy1, en0, en1, done0, done1, mux_out0, mux_out1;
    logic [2:0] sel0, sel1;
    logic [7:0] mux_in0, mux_in1, result0, result1;
`ifdef MUX8_SCAN_CHECK_EN
    logic       mism0, mism1;
`endif

    // Instance 0 sees an ideal mux with a 2-cycle output delay, optionally stuck at 0.
    logic stuck0 = 1'b0;
    logic pipe0_a = 1'b0, pipe0_b = 1'b0;
    always @(posedge clk) begin
        pipe0_a <= mux_in0[sel0];
        pipe0_b <= pipe0_a;
    end
    assign mux_out0 = stuck0 ? 1'b0 : pipe0_b;
    assign mux_out1 = mux_in1[sel1];

    mux8_scan_ctrl #(.DWELL(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .data_in(data0),
        .busy(busy0), .mux_en(en0), .mux_sel(sel0), .mux_in(mux_in0),
        .mux_out(mux_out0), .result(result0),
`ifdef MUX8_SCAN_CHECK_EN
        .mismatch(mism0),
`endif
        .done(done0)
    );

    mux8_scan_ctrl #(.DWELL(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1),
        .busy(busy1), .mux_en(en1), .mux_sel(sel1), .mux_in(mux_in1),
        .mux_out(mux_out1), .result(result1),
`ifdef MUX8_SCAN_CHECK_EN
        .mismatch(mism1),
`endif
        .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input int unsigned a, input int unsigned b);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, a, b, cyc);
    endtask

    // Monitors: pop an expectation whenever a done pulse appears.
    logic done0_prev = 1'b0, done1_prev = 1'b0;
    always @(negedge clk) begin : mon0
        exp_t e;
        if (done0) begin
            chk("done0_width", {31'b0, done0_prev}, 32'd0);
            if (q0.size() == 0) begin
                fail_now("done0_unexpected", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("result0", {24'b0, result0}, {24'b0, e.res});
                chk("done0_cycle", cyc, e.cyc);
`ifdef MUX8_SCAN_CHECK_EN
                chk("mismatch0", {31'b0, mism0}, {31'b0, e.mism});
`endif
            end
        end else if (q0.size() != 0 && cyc > q0[0].cyc) begin
            fail_now("done0_timeout", cyc, q0[0].cyc);
            void'(q0.pop_front());
        end
        done0_prev = done0;
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            chk("done1_width", {31'b0, done1_prev}, 32'd0);
            if (q1.size() == 0) begin
                fail_now("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("result1", {24'b0, result1}, {24'b0, e.res});
                chk("done1_cycle", cyc, e.cyc);
`ifdef MUX8_SCAN_CHECK_EN
                chk("mismatch1", {31'b0, mism1}, {31'b0, e.mism});
`endif
            end
        end else if (q1.size() != 0 && cyc > q1[0].cyc) begin
            fail_now("done1_timeout", cyc, q1[0].cyc);
            void'(q1.pop_front());
        end
        done1_prev = done1;
    end

    // Reference: a healthy mux returns the word unchanged; a stuck-at-0 mux returns 0.
    function automatic exp_t model(input logic [7:0] d, input logic stuck, input int unsigned lat);
        exp_t e;
        e.res  = stuck ? 8'h00 : d;
        e.mism = (e.res != d);
        e.cyc  = cyc + 1 + lat;
        return e;
    endfunction

    task automatic drive_start(input int inst, input logic [7:0] d);
        @(posedge clk); #1;
        if (inst == 0) begin
            start0 = 1'b1; data0 = d;
            q0.push_back(model(d, stuck0, LAT0));
        end else begin
            start1 = 1'b1; data1 = d;
            q1.push_back(model(d, 1'b0, LAT1));
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        for (int i = 0; i < 2 * int'(LAT0) + 10; i++) begin
            if ((inst == 0 ? q0.size() : q1.size()) == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy0", {31'b0, busy0}, 0);  chk("rst_busy1", {31'b0, busy1}, 0);
        chk("rst_en0", {31'b0, en0}, 0);      chk("rst_en1", {31'b0, en1}, 0);
        chk("rst_sel0", {29'b0, sel0}, 0);    chk("rst_sel1", {29'b0, sel1}, 0);
        chk("rst_muxin0", {24'b0, mux_in0}, 0);
        chk("rst_muxin1", {24'b0, mux_in1}, 0);
        chk("rst_result0", {24'b0, result0}, 0);
        chk("rst_result1", {24'b0, result1}, 0);
        chk("rst_done0", {31'b0, done0}, 0);  chk("rst_done1", {31'b0, done1}, 0);
`ifdef MUX8_SCAN_CHECK_EN
        chk("rst_mism0", {31'b0, mism0}, 0);  chk("rst_mism1", {31'b0, mism1}, 0);
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic scan plus a start pulse while busy that must be ignored.
        drive_start(0, 8'hAA);
        repeat (9) @(posedge clk);
        #1 start0 = 1'b1; data0 = 8'h55;
        @(posedge clk); #1 start0 = 1'b0;
        chk("ignored_muxin0", {24'b0, mux_in0}, 32'hAA);
        chk("ignored_busy0", {31'b0, busy0}, 1);
        wait_idle(0);
        chk("after_muxin0", {24'b0, mux_in0}, 32'hAA);

        // Back-to-back: second start in the first IDLE cycle after done.
        repeat (3) @(posedge clk);
        drive_start(0, 8'h00);
        for (int i = 0; i < int'(LAT0) + 10; i++) begin
            @(negedge clk);
            if (done0) break;
        end
        @(posedge clk); #1;
        chk("b2b_busy0", {31'b0, busy0}, 0);
        chk("b2b_sel0", {29'b0, sel0}, 7);
        chk("b2b_en0", {31'b0, en0}, 0);
        start0 = 1'b1; data0 = 8'hFF;
        q0.push_back(model(8'hFF, stuck0, LAT0));
        @(posedge clk); #1 start0 = 1'b0;
        chk("b2b_accept_busy0", {31'b0, busy0}, 1);
        chk("b2b_accept_sel0", {29'b0, sel0}, 0);
        wait_idle(0);
        repeat (6) @(negedge clk);
        chk("hold_result0", {24'b0, result0}, 32'hFF);
        chk("hold_sel0", {29'b0, sel0}, 7);
        chk("hold_busy0", {31'b0, busy0}, 0);

        // Reset mid-scan: outputs clear at once, pending done must never appear.
        d = 8'($urandom_range(1, 255));
        drive_start(0, d);
        repeat (18) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        q0.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (LAT0 + 10) @(negedge clk);
        drive_start(0, 8'h3C);
        wait_idle(0);

        // Stuck-at-0 mux: result zero and mismatch flagged.
        stuck0 = 1'b1;
        drive_start(0, 8'hAA);
        wait_idle(0);
        stuck0 = 1'b0;

        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            drive_start(0, 8'($urandom));
            wait_idle(0);
        end

        // Short dwell instance.
        drive_start(1, 8'h81);
        wait_idle(1);
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            drive_start(1, 8'($urandom));
            wait_idle(1);
        end

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux8_scan_ctrl
`default_nettype wire
